// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counting timer with an interrupt
// request output for one CP0 HWInt bit.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | stopped; waits for Enable, clears irq_flag on the way out
//   LOAD   | copies PRESET into COUNT
//   CNT    | counts down; expires on COUNT<=1, stops early if Enable drops
//   INT    | expiry: one-shot clears Enable, auto-reload drops irq_flag
//
// A bus write cycle performs only the register write; the sequencer,
// COUNT and irq_flag all hold for that cycle.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'b00;
    localparam logic [1:0] A_PRESET = 2'b01;
    localparam logic [1:0] A_COUNT  = 2'b10;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic [1:0]  reg_sel;
    logic        unused_addr;

    assign reg_sel     = Addr[3:2];
    assign unused_addr = ^Addr[31:4];

    // Register writes take priority over the sequencer, which runs only on
    // non-write cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ctrl     <= 4'h0;
            preset   <= 32'h0;
            count    <= 32'h0;
            irq_flag <= 1'b0;
        end else if (WE) begin
            case (reg_sel)
                A_CTRL:   ctrl   <= Din[3:0];
                A_PRESET: preset <= Din;
                default:  ;
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl[0]) begin
                        state    <= S_LOAD;
                        irq_flag <= 1'b0;
                    end
                end
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!ctrl[0]) begin
                        state <= S_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count    <= 32'h0;
                        irq_flag <= 1'b1;
                        state    <= S_INT;
                    end
                end
                S_INT: begin
                    // Mode 00 latches the request until software re-enables.
                    if (ctrl[2:1] == 2'b00) begin
                        ctrl[0] <= 1'b0;
                    end else begin
                        irq_flag <= 1'b0;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read mux; unimplemented CTRL bits and the reserved word read as zero.
    always_comb begin
        Dout = 32'h0;
        case (reg_sel)
            A_CTRL:   Dout = {28'h0, ctrl};
            A_PRESET: Dout = preset;
            A_COUNT:  Dout = count;
            default:  Dout = 32'h0;
        endcase
    end

    // The mask gates only the output; irq_flag runs the same either way.
    assign IRQ = irq_flag & ctrl[3];

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counting timer that raises a hardware interrupt request for the coprocessor-0 interrupt logic. It sits on the bridge side of the CPU, directly upstream of CP0. Its IRQ output drives one bit of CP0's HWInt[5:0] (TC0 → HWInt[0], TC1 → HWInt[1]). Software programs it with sw/lw through the bridge, and CP0 converts its IRQ into an interrupt exception (ExcCode 0).

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Addr  input  30 (Addr[31:2])  word address from bridge; only Addr[3:2] decoded
- WE  input  1  write enable from bridge (already qualified by address range)
- Din  input  32  write data
- Dout  output  32  read data, combinational from Addr[3:2]
- IRQ  output  1  interrupt request to CP0 HWInt bit; combinational = irq_flag & CTRL[3]

## Operation
Register map (Addr[3:2]):
- 00 CTRL
  - [0] Enable
  - [2:1] Mode: 00 = one-shot; any non-zero = auto-reload
  - [3] IM, the interrupt mask
  - [31:4] read 0
- 01 PRESET: 32-bit reload value
- 10 COUNT: read-only current count
- 11 reserved: reads 0, writes ignored

Writes:
- CTRL stores Din[3:0] only.
- PRESET stores all of Din.
- Writes to COUNT or reserved are discarded.
- Any cycle with WE=1 performs only the register write: the FSM holds its state, COUNT does not change, and irq_flag does not change.

FSM, evaluated only when WE=0:
- IDLE: if CTRL[0]=1, go to LOAD and clear irq_flag; otherwise stay.
- LOAD: COUNT ← PRESET; go to CNT.
- CNT:
  - if CTRL[0]=0: go to IDLE; COUNT holds.
  - else if COUNT > 1: COUNT ← COUNT−1.
  - else: COUNT ← 0, irq_flag ← 1, go to INT.
- INT:
  - Mode=00: CTRL[0] ← 0, irq_flag stays 1.
  - Mode≠00: irq_flag ← 0.
  - Both modes go to IDLE.

Consequences:
- One-shot mode holds IRQ high (when IM=1) until software writes CTRL with Enable=1 again or resets.
- Auto-reload mode produces a one-cycle IRQ pulse per period.
- IM only gates the output. The internal flag behaves identically whether IM is set or not.

## Timing
Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, IRQ=0, Dout=0 (for any address).

All latencies below are measured from edge E0, the edge that samples a CTRL write with Enable=1 while in IDLE. Let N = PRESET.
- E1: state → LOAD.
- E2: COUNT=N, state → CNT.
- E(2+max(N,1)): COUNT=0, irq_flag=1, state → INT.
- Next edge: INT → IDLE.
  - Auto-reload: irq_flag drops, so the pulse is exactly 1 cycle. The following edge re-enters LOAD, giving a period of max(N,1)+3 cycles.
  - One-shot: Enable clears and IRQ stays high.

Boundary conditions:
- PRESET=0 and PRESET=1 behave identically: IRQ at E3.
- PRESET=0xFFFFFFFF counts down without overflow. COUNT never wraps below 0.
- Each WE cycle during CNT delays expiry by exactly one cycle.
- Clearing Enable during CNT freezes COUNT. Re-enabling from IDLE reloads from PRESET (no resume).
- Writing PRESET during CNT does not affect the current count, only the next LOAD.
- Reset asserted in any state returns to reset values on that edge, regardless of WE.
- Dout reflects a register write from the edge after that write.

## Test plan
- Reset then read all four addresses → Dout=0 for each; IRQ=0.
- PRESET=5, CTRL=0x9 (IM=1, one-shot, enable) at E0 → IRQ rises at E7, stays high for 20+ cycles, and CTRL reads 0x8 after E8. Rewriting CTRL=0x9 → IRQ falls at the following edge.
- PRESET=3, CTRL=0xB (auto-reload, IM=1) → 1-cycle IRQ pulses at E5, E11, E17 (period 6).
- PRESET=0, CTRL=0x9 → IRQ at E3. PRESET=4, CTRL=0x1 (IM=0) → IRQ never asserts, but COUNT reaches 0 and Enable clears.
- PRESET=10, enable, write CTRL=0x8 while COUNT=6 → COUNT stays 6, no IRQ. Issue 2 PRESET writes during a second countdown → expiry delayed by 2 cycles.
- Assert reset while in CNT with COUNT=7 → next cycle all registers 0, state IDLE, IRQ=0. Connect IRQ to CP0 HWInt[0] with SR.IM[10] and IE set → CP0 Req asserts the cycle IRQ rises.
